// File: rtl/oryx_if_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state type, the PC step and the reset instruction.
package oryx_if_pkg;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } fetch_state_t;

  localparam int unsigned PC_STEP = 4;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/if_fifo.sv
// Synchronous instruction buffer: registered storage, head always visible.
// Ports: push/wdata in, pop in, flush in (beats push), rdata/count/full/empty out.
module if_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    pop,
  input  logic                    flush,
  output logic [DATA_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [AW:0]       cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  // A full buffer still accepts a word when the head leaves.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push && !flush) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, redirect flush, IR buffer.
// Ports: imem req/addr/gnt/rvalid/rdata, redirect in, ir/ir_pc/ir_valid/ir_ready;
// perf_fetch_cnt/perf_stall_cnt exist only when IF_PERF_CNT_EN is defined.
module instr_fetch_unit
  import oryx_if_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  input  logic               ir_ready
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  fetch_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] rpc_q, rpc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   disc_q, disc_d;

  logic [PC_W+INSTR_W-1:0] fdata;
  logic [CW-1:0]   fcount;
  logic            ffull;
  logic            fempty;
  logic [CW:0]     inflight;
  logic [PC_W-1:0] redir_pc;
  logic            issue;
  logic            resp;
  logic            drop;
  logic            push;
  logic            pop;

  // Every request in flight owns a buffer slot, so the FIFO never overflows.
  assign inflight  = {1'b0, fcount} + {1'b0, out_q};
  assign imem_req  = ~rst & (state_q == S_RUN)
                   & (inflight < DEPTH_W);
  assign imem_addr = pc_q;
  assign issue     = imem_req & imem_gnt;
  assign resp      = imem_rvalid & (out_q != '0);
  assign drop      = resp & (disc_q != '0);
  assign push      = resp & ~drop;
  assign pop       = ir_valid & ir_ready;
  assign redir_pc  = redirect_pc & ~PC_W'(3);

  assign ir_valid = ~fempty;
  assign ir       = fdata[PC_W +: INSTR_W];
  assign ir_pc    = fdata[PC_W-1:0];

  always_comb begin
    out_d = out_q;
    if (issue && !resp) out_d = out_q + CW'(1);
    else if (!issue && resp) out_d = out_q - CW'(1);
  end

  // rpc tracks the address of the next response that will be kept.
  always_comb begin
    pc_d    = pc_q;
    rpc_d   = rpc_q;
    disc_d  = disc_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = redir_pc;
      rpc_d   = redir_pc;
      disc_d  = out_d;
      state_d = (out_d != '0) ? S_FLUSH : S_RUN;
    end else begin
      if (issue) pc_d = pc_q + STEP;
      if (push)  rpc_d = rpc_q + STEP;
      if (drop)  disc_d = disc_q - CW'(1);
      if (state_q == S_FLUSH && disc_d == '0)
        state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      rpc_q   <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
    end
  end

  if_fifo #(
    .DATA_W (PC_W + INSTR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({imem_rdata, rpc_q}),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (fdata),
    .count (fcount),
    .full  (ffull),
    .empty (fempty)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (pop) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (ir_ready && !ir_valid)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

  a_rvalid_owed: assert property (
    @(posedge clk) disable iff (rst)
    !(imem_rvalid && (out_q == '0)));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && ffull && !pop && !redirect_valid));

endmodule
